lif_neuron_scheduler: RTL and testbench



---
 rtl/snn_pkg.sv | 16 +
 rtl/lif_fire_unit.sv | 19 +
 rtl/lif_neuron_scheduler.sv | 88 ++++++++
 tb/tb_lif_neuron_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding and arithmetic helpers for the LIF neuron datapath
package snn_pkg;
    localparam int W_DEF = 8;
    typedef enum logic [2:0] {IDLE, ACCUM, SCAN, FIRE, DONE} state_t;
    function automatic int sat_add(int a, int b, int w);
        int s, hi, lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
    // Subtracting the arithmetic shift moves toward zero; -1 decays to 0.
    function automatic int leak(int p, int sh);
        return p - (p >>> sh);
    endfunction
endpackage

// File: rtl/lif_fire_unit.sv
// lif_fire_unit: combinational threshold compare, saturating accumulate and leak
module lif_fire_unit
    import snn_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int LEAK_SHIFT = 2
) (
    input  logic signed [W-1:0] acc_pot,
    input  logic signed [W-1:0] weight,
    input  logic signed [W-1:0] scan_pot,
    input  logic signed [W-1:0] thr,
    output logic                fire,
    output logic signed [W-1:0] sum,
    output logic signed [W-1:0] leaked
);
    assign fire   = scan_pot >= thr;
    assign sum    = W'(sat_add(int'(acc_pot), int'(weight), W));
    assign leaked = W'(leak(int'(scan_pot), LEAK_SHIFT));
endmodule

// File: rtl/lif_neuron_scheduler.sv
// lif_neuron_scheduler: time-multiplexed LIF neurons with accumulate and scan/fire phases
module lif_neuron_scheduler
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = 8,
    parameter int W          = W_DEF,
    parameter int LEAK_SHIFT = 2,
    parameter int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     threshold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [W-1:0]     in_weight,
    input  logic             in_last,
    output logic             spk_valid,
    input  logic             spk_ready,
    output logic [IDX_W-1:0] spk_idx,
    output logic             busy,
    output logic             done
);
    state_t                state;
    logic signed [W-1:0]   thr_q;
    logic [IDX_W-1:0]      idx;
    logic signed [W-1:0]   pot [N_NEURONS];
    logic                  fire;
    logic signed [W-1:0]   sum;
    logic signed [W-1:0]   leaked;
    logic                  last;

    lif_fire_unit #(.W(W), .LEAK_SHIFT(LEAK_SHIFT)) u_fire (
        .acc_pot  (pot[in_idx]),
        .weight   (in_weight),
        .scan_pot (pot[idx]),
        .thr      (thr_q),
        .fire     (fire),
        .sum      (sum),
        .leaked   (leaked)
    );

    assign last      = idx == IDX_W'(N_NEURONS - 1);
    assign in_ready  = state == ACCUM;
    assign spk_valid = state == FIRE;
    assign spk_idx   = spk_valid ? idx : '0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            thr_q <= '0;
            idx   <= '0;
            for (int k = 0; k < N_NEURONS; k++) pot[k] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    thr_q <= threshold;
                    state <= ACCUM;
                end
                ACCUM: if (in_valid) begin
                    pot[in_idx] <= sum;
                    if (in_last) begin
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: if (fire) begin
                    state <= FIRE;
                end else begin
                    pot[idx] <= leaked;
                    idx      <= idx + 1'b1;
                    state    <= last ? DONE : SCAN;
                end
                // A fired neuron is cleared and skips this timestep's leak.
                FIRE: if (spk_ready) begin
                    pot[idx] <= '0;
                    idx      <= idx + 1'b1;
                    state    <= last ? DONE : SCAN;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// tb_lif_neuron_scheduler: scoreboard bench; expected spikes queued at scan start, popped on handshake
module tb_lif_neuron_scheduler;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic [7:0] threshold = '0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [2:0] in_idx = '0;
    logic [7:0] in_weight = '0;
    logic       in_last = 0;
    logic       spk_valid;
    logic       spk_ready = 0;
    logic [2:0] spk_idx;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pot[8];
    int exp_q[$];
    int ev_i[$];
    int ev_w[$];
    int bp = 0;
    bit poke = 0;

    lif_neuron_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .threshold (threshold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_weight (in_weight),
        .in_last   (in_last),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_idx   (spk_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int msat(int v);
        return v > 127 ? 127 : (v < -128 ? -128 : v);
    endfunction

    task automatic check_pots();
        for (int k = 0; k < 8; k++) check($sformatf("pot%0d", k), int'(dut.pot[k]), m_pot[k]);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int k = 0; k < 8; k++) m_pot[k] = 0;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_done", done, 0);
        check("rst_spk_idx", int'(spk_idx), 0);
        check_pots();
    endtask

    task automatic send(int i, int w, bit last);
        bit ok = 0;
        in_valid = 1;
        in_idx = 3'(i);
        in_weight = 8'(w);
        in_last = last;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last = 0;
        if (!ok) check("in_ready_wait", 0, 1);
        else m_pot[i] = msat(m_pot[i] + w);
    endtask

    task automatic run(int thr);
        bit got_done = 0;
        int held = 0;
        int held_idx = 0;
        start = 1;
        threshold = 8'(thr);
        @(posedge clk);
        #1;
        start = 0;
        check("accum_ready", in_ready, 1);
        if (poke) begin
            start = 1;
            threshold = 8'(-100);
            @(posedge clk);
            #1;
            start = 0;
            threshold = 8'(thr);
            check("start_ignored", in_ready, 1);
        end
        if (ev_i.size() == 0) begin
            ev_i.push_back(0);
            ev_w.push_back(0);
        end
        for (int k = 0; k < ev_i.size(); k++) begin
            send(ev_i[k], ev_w[k], k == ev_i.size() - 1);
            if (k % 2 == 1) begin
                @(posedge clk);
                #1;
            end
        end
        ev_i.delete();
        ev_w.delete();
        @(negedge clk);
        check("scan_no_ready", in_ready, 0);
        check("scan_busy", busy, 1);
        for (int k = 0; k < 8; k++) begin
            if (m_pot[k] >= thr) begin
                exp_q.push_back(k);
                m_pot[k] = 0;
            end else begin
                m_pot[k] = m_pot[k] - (m_pot[k] >>> 2);
            end
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
            if (!spk_valid) spk_ready = 0;
            else if (held < bp) begin
                if (held > 0) check("spk_stable", int'(spk_idx), held_idx);
                else held_idx = int'(spk_idx);
                held++;
                spk_ready = 0;
            end else begin
                spk_ready = 1;
                held = 0;
                if (exp_q.size() == 0) check("spk_extra", int'(spk_idx), -1);
                else check("spk_idx", int'(spk_idx), exp_q.pop_front());
            end
        end
        spk_ready = 0;
        check("done_seen", got_done, 1);
        check("spk_missing", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
        check_pots();
    endtask

    initial begin
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // T1 basic fire
        ev_i = '{3, 3}; ev_w = '{6, 5};
        run(10);
        // T2 equality fires, 7 leaks to 6, then to 5
        ev_i = '{1, 2}; ev_w = '{8, 7};
        run(8);
        check("t2_pot2", int'(dut.pot[2]), 6);
        run(8);
        check("t2_pot2_next", int'(dut.pot[2]), 5);
        // T3 saturation both ways
        do_reset();
        ev_i = '{0, 0, 5, 5}; ev_w = '{100, 100, -100, -100};
        run(127);
        // T4 backpressure
        do_reset();
        bp = 5;
        ev_i = '{0, 2, 7}; ev_w = '{5, 3, 1};
        run(1);
        bp = 0;
        // T5 negative threshold
        do_reset();
        run(-4);
        // T6 start ignored in ACCUM, then reset while firing
        do_reset();
        poke = 1;
        ev_i = '{4}; ev_w = '{5};
        run(5);
        poke = 0;
        ev_i = '{6}; ev_w = '{20};
        start = 1;
        threshold = 8'(-4);
        @(posedge clk);
        #1;
        start = 0;
        send(6, 20, 1);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (spk_valid) begin
                ok = 1;
                break;
            end
        end
        check("fire_reached", ok, 1);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int k = 0; k < 8; k++) m_pot[k] = 0;
        ev_i.delete();
        ev_w.delete();
        check("abort_spk_valid", spk_valid, 0);
        check("abort_busy", busy, 0);
        check_pots();
        repeat (3) @(negedge clk);
        check("abort_no_spike", spk_valid, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
